// File: rtl/idu.sv
//------------------------------------------------------------------------------
// Module      : idu
// Description : RV32I instruction decode unit. Registers one decoded slot per
//               cycle, owns the register file and redirects fetch on JAL.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module idu #(
    parameter bit DEC_JAL_REDIRECT = 1'b1,
    parameter int SQUASH_DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_location,
    input  logic [31:0] instr_to_dec,
    input  logic        flush_from_exe,
    output logic        flush_from_dec,
    output logic [31:0] flush_addr_dec,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_rs1_data,
    output logic [31:0] dec_rs2_data,
    output logic [4:0]  dec_rd,
    output logic        dec_rd_we,
    output logic [31:0] dec_imm,
    output logic        dec_illegal
);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_MISC   = 7'b0001111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    localparam int                 c_CNT_W       = (SQUASH_DEPTH < 2) ? 1 : $clog2(SQUASH_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_SQUASH_LOAD = c_CNT_W'(SQUASH_DEPTH);

    logic [31:0]        r_regs [32];
    logic [c_CNT_W-1:0] r_squash_cnt;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_bubble;
    logic        w_legal;
    logic        w_writes_rd;
    logic [31:0] w_imm;
    logic [31:0] w_imm_j;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic        w_jal_redirect;

    assign w_opcode = instr_to_dec[6:0];
    assign w_rd     = instr_to_dec[11:7];
    assign w_rs1    = instr_to_dec[19:15];
    assign w_rs2    = instr_to_dec[24:20];

    assign w_bubble = (instr_to_dec == 32'h0) || (r_squash_cnt != '0) || flush_from_exe;

    assign w_imm_j = {{11{instr_to_dec[31]}}, instr_to_dec[31], instr_to_dec[19:12],
                      instr_to_dec[20], instr_to_dec[30:21], 1'b0};

    always_comb begin
        w_legal     = 1'b0;
        w_writes_rd = 1'b0;
        w_imm       = 32'h0;
        if (instr_to_dec[1:0] == 2'b11) begin
            case (w_opcode)
                c_OP_LUI, c_OP_AUIPC: begin
                    w_legal     = 1'b1;
                    w_writes_rd = 1'b1;
                    w_imm       = {instr_to_dec[31:12], 12'h000};
                end
                c_OP_JAL: begin
                    w_legal     = 1'b1;
                    w_writes_rd = 1'b1;
                    w_imm       = w_imm_j;
                end
                c_OP_JALR, c_OP_LOAD, c_OP_IMM: begin
                    w_legal     = 1'b1;
                    w_writes_rd = 1'b1;
                    w_imm       = {{20{instr_to_dec[31]}}, instr_to_dec[31:20]};
                end
                c_OP_SYSTEM: begin
                    w_legal = 1'b1;
                    w_imm   = {{20{instr_to_dec[31]}}, instr_to_dec[31:20]};
                end
                c_OP_STORE: begin
                    w_legal = 1'b1;
                    w_imm   = {{20{instr_to_dec[31]}}, instr_to_dec[31:25], instr_to_dec[11:7]};
                end
                c_OP_BRANCH: begin
                    w_legal = 1'b1;
                    w_imm   = {{19{instr_to_dec[31]}}, instr_to_dec[31], instr_to_dec[7],
                               instr_to_dec[30:25], instr_to_dec[11:8], 1'b0};
                end
                c_OP_OP: begin
                    w_legal     = 1'b1;
                    w_writes_rd = 1'b1;
                end
                c_OP_MISC: begin
                    w_legal = 1'b1;
                end
                default: begin
                    w_legal = 1'b0;
                end
            endcase
        end
    end

    // Write-first read: a same-cycle writeback to the source register wins.
    always_comb begin
        w_rs1_data = 32'h0;
        w_rs2_data = 32'h0;
        if (w_rs1 != 5'd0) begin
            w_rs1_data = (wb_en && (wb_rd == w_rs1)) ? wb_data : r_regs[w_rs1];
        end
        if (w_rs2 != 5'd0) begin
            w_rs2_data = (wb_en && (wb_rd == w_rs2)) ? wb_data : r_regs[w_rs2];
        end
    end

    assign w_jal_redirect = DEC_JAL_REDIRECT && rst_n && !w_bubble && (w_opcode == c_OP_JAL);
    assign flush_from_dec = w_jal_redirect;
    assign flush_addr_dec = w_jal_redirect ? (instr_location + w_imm_j) : 32'h0;

    always_ff @(posedge clk) begin
        if (wb_en && (wb_rd != 5'd0)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_squash_cnt <= '0;
        end else if (flush_from_exe) begin
            r_squash_cnt <= '0;
        end else if (w_jal_redirect) begin
            r_squash_cnt <= c_SQUASH_LOAD;
        end else if (r_squash_cnt != '0) begin
            r_squash_cnt <= r_squash_cnt - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || w_bubble) begin
            dec_valid    <= 1'b0;
            dec_pc       <= 32'h0;
            dec_instr    <= 32'h0;
            dec_rs1_data <= 32'h0;
            dec_rs2_data <= 32'h0;
            dec_rd       <= 5'd0;
            dec_rd_we    <= 1'b0;
            dec_imm      <= 32'h0;
            dec_illegal  <= 1'b0;
        end else begin
            dec_valid    <= 1'b1;
            dec_pc       <= instr_location;
            dec_instr    <= instr_to_dec;
            dec_rs1_data <= w_rs1_data;
            dec_rs2_data <= w_rs2_data;
            dec_rd       <= w_rd;
            dec_rd_we    <= w_writes_rd && (w_rd != 5'd0);
            dec_imm      <= w_imm;
            dec_illegal  <= !w_legal;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_idu.sv
//------------------------------------------------------------------------------
// Module      : tb_idu
// Description : Directed and random checks of idu against a behavioural model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_idu;

    localparam bit DEC_JAL_REDIRECT = 1'b1;
    localparam int SQUASH_DEPTH     = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr_location;
    logic [31:0] instr_to_dec;
    logic        flush_from_exe;
    logic        flush_from_dec;
    logic [31:0] flush_addr_dec;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic [31:0] dec_rs1_data;
    logic [31:0] dec_rs2_data;
    logic [4:0]  dec_rd;
    logic        dec_rd_we;
    logic [31:0] dec_imm;
    logic        dec_illegal;

    idu #(
        .DEC_JAL_REDIRECT(DEC_JAL_REDIRECT),
        .SQUASH_DEPTH    (SQUASH_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_location(instr_location),
        .instr_to_dec  (instr_to_dec),
        .flush_from_exe(flush_from_exe),
        .flush_from_dec(flush_from_dec),
        .flush_addr_dec(flush_addr_dec),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .dec_valid     (dec_valid),
        .dec_pc        (dec_pc),
        .dec_instr     (dec_instr),
        .dec_rs1_data  (dec_rs1_data),
        .dec_rs2_data  (dec_rs2_data),
        .dec_rd        (dec_rd),
        .dec_rd_we     (dec_rd_we),
        .dec_imm       (dec_imm),
        .dec_illegal   (dec_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_regs [32];
    int          m_squash = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] w);
        case (w[6:0])
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Immediates rebuilt from their arithmetic weights rather than bit concatenation.
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        int s;
        s = w[31] ? -1 : 0;
        case (w[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
                return 32'(s * 2048 + int'(w[30:20]));
            7'b0100011:
                return 32'(s * 2048 + int'(w[30:25]) * 32 + int'(w[11:7]));
            7'b1100011:
                return 32'(s * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
            7'b0110111, 7'b0010111:
                return w & 32'hFFFF_F000;
            7'b1101111:
                return 32'(s * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
            default:
                return 32'h0;
        endcase
    endfunction

    function automatic bit has_rd(input logic [31:0] w);
        return w[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                              7'b0000011, 7'b0010011, 7'b0110011};
    endfunction

    function automatic bit uses_rs1(input logic [31:0] w);
        return w[6:0] inside {7'b1100111, 7'b0000011, 7'b0010011, 7'b0100011,
                              7'b1100011, 7'b0110011};
    endfunction

    function automatic bit uses_rs2(input logic [31:0] w);
        return w[6:0] inside {7'b0100011, 7'b1100011, 7'b0110011};
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] r, input logic we,
                                             input logic [4:0] wrd, input logic [31:0] wd);
        if (r == 5'd0) return 32'h0;
        if (we && wrd == r) return wd;
        return m_regs[r];
    endfunction

    // One slot: drive after the falling edge, check comb redirect, then the registered result.
    task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] w,
                        input logic fexe, input logic we, input logic [4:0] wrd,
                        input logic [31:0] wd);
        bit          bub;
        bit          exp_flush;
        logic [31:0] exp_addr;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        instr_location = pc;
        instr_to_dec   = w;
        flush_from_exe = fexe;
        wb_en          = we;
        wb_rd          = wrd;
        wb_data        = wd;
        #1;
        bub       = (w == 32'h0) || (m_squash != 0) || fexe;
        exp_flush = DEC_JAL_REDIRECT && !bub && (w[6:0] == 7'b1101111);
        exp_addr  = exp_flush ? pc + ref_imm(w) : 32'h0;
        e_rs1     = ref_read(w[19:15], we, wrd, wd);
        e_rs2     = ref_read(w[24:20], we, wrd, wd);
        check({tag, ".flush"}, 32'(flush_from_dec), 32'(exp_flush));
        check({tag, ".faddr"}, flush_addr_dec, exp_addr);
        if (fexe) m_squash = 0;
        else if (exp_flush) m_squash = SQUASH_DEPTH;
        else if (m_squash > 0) m_squash--;
        if (we && wrd != 5'd0) m_regs[wrd] = wd;
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(dec_valid), 32'(!bub));
        if (bub) begin
            check({tag, ".zero"}, dec_pc | dec_instr | dec_rs1_data | dec_rs2_data | dec_imm
                  | 32'(dec_rd) | 32'(dec_rd_we) | 32'(dec_illegal), 32'h0);
        end else begin
            check({tag, ".pc"}, dec_pc, pc);
            check({tag, ".instr"}, dec_instr, w);
            check({tag, ".illegal"}, 32'(dec_illegal), 32'(!is_legal(w)));
            check({tag, ".imm"}, dec_imm, is_legal(w) ? ref_imm(w) : 32'h0);
            check({tag, ".rd_we"}, 32'(dec_rd_we), 32'(is_legal(w) && has_rd(w) && w[11:7] != 5'd0));
            if (is_legal(w) && has_rd(w)) check({tag, ".rd"}, 32'(dec_rd), 32'(w[11:7]));
            if (is_legal(w) && uses_rs1(w)) check({tag, ".rs1"}, dec_rs1_data, e_rs1);
            if (is_legal(w) && uses_rs2(w)) check({tag, ".rs2"}, dec_rs2_data, e_rs2);
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 15);
        if (k == 0) return 32'h0;
        if (k == 1) return w;
        if (k < 4) return {w[31:7], 7'b1101111};
        case ($urandom_range(0, 10))
            0: w[6:0] = 7'b0110111;
            1: w[6:0] = 7'b0010111;
            2: w[6:0] = 7'b1100111;
            3: w[6:0] = 7'b1100011;
            4: w[6:0] = 7'b0000011;
            5: w[6:0] = 7'b0100011;
            6: w[6:0] = 7'b0010011;
            7: w[6:0] = 7'b0110011;
            8: w[6:0] = 7'b0001111;
            9: w[6:0] = 7'b1110011;
            default: w[6:0] = 7'b1101111;
        endcase
        return w;
    endfunction

    localparam logic [31:0] c_ADD_7_5_6 = {7'd0, 5'd6, 5'd5, 3'd0, 5'd7, 7'b0110011};
    localparam logic [31:0] c_ADDI_1_M1 = {12'hFFF, 5'd0, 3'd0, 5'd1, 7'b0010011};
    localparam logic [31:0] c_SW_M4     = {7'h7F, 5'd6, 5'd5, 3'b010, 5'h1C, 7'b0100011};
    localparam logic [31:0] c_JAL_100   = {1'b0, 10'h080, 1'b0, 8'h00, 5'd1, 7'b1101111};
    localparam logic [31:0] c_ADDI_4_3  = {12'h000, 5'd3, 3'd0, 5'd4, 7'b0010011};
    localparam logic [31:0] c_ADDI_4_0  = {12'h000, 5'd0, 3'd0, 5'd4, 7'b0010011};

    initial begin
        rst_n          = 1'b0;
        instr_location = 32'h40;
        instr_to_dec   = c_JAL_100;
        flush_from_exe = 1'b0;
        wb_en          = 1'b0;
        wb_rd          = 5'd0;
        wb_data        = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.flush", 32'(flush_from_dec), 32'h0);
        check("reset.valid", 32'(dec_valid), 32'h0);
        check("reset.outs", dec_pc | dec_instr | dec_rs1_data | dec_rs2_data | dec_imm
              | 32'(dec_rd) | 32'(dec_rd_we) | 32'(dec_illegal), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 1; r < 32; r++) step("init", 32'h0, 32'h0, 1'b0, 1'b1, 5'(r), $urandom);

        step("w_x5", 32'h0, 32'h0, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
        step("w_x6", 32'h0, 32'h0, 1'b0, 1'b1, 5'd6, 32'hFFFF_FFFF);
        step("add", 32'h10, c_ADD_7_5_6, 1'b0, 1'b0, 5'd0, 32'h0);
        check("add.rs1_const", dec_rs1_data, 32'h0000_1234);
        check("add.rs2_const", dec_rs2_data, 32'hFFFF_FFFF);
        check("add.rd_const", 32'(dec_rd), 32'd7);
        step("addi", 32'h14, c_ADDI_1_M1, 1'b0, 1'b0, 5'd0, 32'h0);
        check("addi.imm_const", dec_imm, 32'hFFFF_FFFF);
        step("sw", 32'h18, c_SW_M4, 1'b0, 1'b0, 5'd0, 32'h0);
        check("sw.imm_const", dec_imm, 32'hFFFF_FFFC);

        instr_location = 32'h40;
        instr_to_dec   = c_JAL_100;
        #1;
        check("jal.addr_const", flush_addr_dec, 32'h140);
        step("jal", 32'h40, c_JAL_100, 1'b0, 1'b0, 5'd0, 32'h0);
        step("sq1", 32'h44, c_ADDI_1_M1, 1'b0, 1'b0, 5'd0, 32'h0);
        step("sq2", 32'h48, c_JAL_100, 1'b0, 1'b0, 5'd0, 32'h0);
        step("tgt", 32'h140, c_ADD_7_5_6, 1'b0, 1'b0, 5'd0, 32'h0);

        step("jal_exe", 32'h60, c_JAL_100, 1'b1, 1'b0, 5'd0, 32'h0);
        step("jal2", 32'h64, c_JAL_100, 1'b0, 1'b0, 5'd0, 32'h0);
        step("exe_in_sq", 32'h68, c_ADDI_1_M1, 1'b1, 1'b0, 5'd0, 32'h0);
        step("after_exe", 32'h6C, c_ADD_7_5_6, 1'b0, 1'b0, 5'd0, 32'h0);

        step("byp", 32'h70, c_ADDI_4_3, 1'b0, 1'b1, 5'd3, 32'h0000_00A5);
        check("byp.rs1_const", dec_rs1_data, 32'h0000_00A5);
        step("byp_x0", 32'h74, c_ADDI_4_0, 1'b0, 1'b1, 5'd0, 32'h0000_00A5);
        check("byp_x0.rs1_const", dec_rs1_data, 32'h0);

        step("bubble", 32'h78, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        step("illegal", 32'h7C, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 32'h0);
        check("illegal.flag_const", 32'(dec_illegal), 32'h1);

        step("jal_rst", 32'h80, c_JAL_100, 1'b0, 1'b0, 5'd0, 32'h0);
        instr_to_dec = 32'h0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.valid", 32'(dec_valid), 32'h0);
        check("midrst.flush", 32'(flush_from_dec), 32'h0);
        m_squash = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 32'h100, c_ADD_7_5_6, 1'b0, 1'b0, 5'd0, 32'h0);
        check("post_rst.valid_const", 32'(dec_valid), 32'h1);

        for (int n = 0; n < 400; n++) begin
            step("rand", $urandom & 32'hFFFF_FFFC, rand_instr(), ($urandom_range(0, 11) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/idu.md
IDU -- requirements
Module: idu

Interface
- REQ-001: Parameter DEC_JAL_REDIRECT, default 1, meaning: 1 lets decode redirect fetch on JAL; 0 leaves JAL to execute.
- REQ-002: Parameter SQUASH_DEPTH, default 2, meaning: number of arriving fetch slots squashed after a decode redirect.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst_n  input  1  asynchronous, active-low reset.
- REQ-005: instr_location  input  32  PC of the incoming fetch slot.
- REQ-006: instr_to_dec  input  32  incoming instruction word; 32'h0 marks a bubble.
- REQ-007: flush_from_exe  input  1  execute-stage redirect; kills in-flight decode work.
- REQ-008: flush_from_dec  output  1  decode redirect request to fetch.
- REQ-009: flush_addr_dec  output  32  decode redirect target.
- REQ-010: wb_en, wb_rd, wb_data  input  1/5/32  register-file write port from writeback.
- REQ-011: dec_valid  output  1  decode output register holds a live instruction.
- REQ-012: dec_pc, dec_instr  output  32/32  PC and raw word of the live instruction.
- REQ-013: dec_rs1_data, dec_rs2_data  output  32/32  source operand values.
- REQ-014: dec_rd  output  5  destination register index.
- REQ-015: dec_rd_we  output  1  instruction writes rd (rd != 0).
- REQ-016: dec_imm  output  32  sign-extended immediate.
- REQ-017: dec_illegal  output  1  live slot is not a legal RV32I major opcode.

Function
- REQ-018: Incoming slot is a bubble if instr_to_dec == 0, or if squash_cnt != 0, or if flush_from_exe = 1.
- REQ-019: Slot is legal if bits[1:0] = 11 and opcode is one of 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011; otherwise dec_illegal = 1 with dec_valid = 1.
- REQ-020: Immediate is I/S/B/U/J format by opcode, sign-extended from bit 31; R-type, MISC-MEM and illegal slots give 0.
- REQ-021: dec_rd_we = 1 only for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP with rd != 0.
- REQ-022: Output register loads in one cycle (latency 1, no stall); on a bubble it loads dec_valid = 0 and every other output 0.
- REQ-023: 32x32 register file, not reset; x0 reads 0; writes with wb_rd = 0 are dropped.
- REQ-024: Operand read is write-first: if wb_en and wb_rd == rsN != 0 in the same cycle, wb_data is captured.
- REQ-025: flush_from_dec is combinational: 1 iff DEC_JAL_REDIRECT = 1, the slot is not a bubble, and opcode = JAL.
- REQ-026: flush_addr_dec = instr_location + J-immediate, mod 2^32; it is 0 when flush_from_dec = 0.
- REQ-027: When flush_from_dec = 1, the JAL itself still enters the output register; squash_cnt loads SQUASH_DEPTH.
- REQ-028: When squash_cnt != 0, it decrements once per cycle, and the arriving slot is squashed whatever its content, including a JAL.
- REQ-029: flush_from_exe has priority: it forces flush_from_dec = 0, loads a bubble, and clears squash_cnt to 0.

Reset
- REQ-030: While rst_n = 0, dec_valid, dec_pc, dec_instr, operand, rd, dec_rd_we, dec_imm and dec_illegal are 0, and squash_cnt is 0.
- REQ-031: flush_from_dec = 0 while rst_n = 0.
- REQ-032: Asserting reset mid-squash abandons the squash; the first non-bubble slot after release is decoded normally.

Verification
- REQ-033: Write x5 = 0x1234 and x6 = 0xFFFFFFFF, then present ADD x7,x5,x6 at PC 0x10 -> next cycle dec_valid = 1, dec_pc = 0x10, rs1 = 0x1234, rs2 = 0xFFFFFFFF, dec_rd = 7, dec_rd_we = 1.
- REQ-034: Present ADDI x1,x0,-1 -> dec_imm = 0xFFFFFFFF, rs1 = 0; present SW -> dec_rd_we = 0 with correct S-immediate.
- REQ-035: Present JAL x1,+0x100 at PC 0x40 -> same-cycle flush_from_dec = 1 and flush_addr_dec = 0x140; the next 2 slots (0x44, 0x48) give dec_valid = 0; the slot at 0x140 is decoded.
- REQ-036: Present JAL together with flush_from_exe = 1 -> flush_from_dec = 0 and dec_valid = 0; flush_from_exe during a squash -> squash_cnt = 0 next cycle.
- REQ-037: Present wb_en = 1, wb_rd = 3, wb_data = 0xA5 in the same cycle as a slot reading x3 -> rs1 = 0xA5; the same test with wb_rd = 0 -> x0 stays 0.
- REQ-038: Present word 0x00000000 -> bubble; present 0xFFFFFFFF -> dec_valid = 1 and dec_illegal = 1.
